// File: rtl/pll_supervisor.sv
// PLL lock supervisor: qualifies a synchronised PLL lock, sequences the system reset and
// generates per-channel clock enables. Optional lock-loss counter: PLL_SUPERVISOR_LOSS_COUNT_EN.
module pll_supervisor #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int RST_CYCLES  = 16,
  parameter int LOSS_W      = 8
) (
  input  logic                    global_clock,
  input  logic                    reset,
  input  logic                    pll_lock,
  input  logic [NUM_CH*DIV_W-1:0] div,
  input  logic                    loss_clr,
  output logic                    sys_reset,
  output logic                    ready,
  output logic [NUM_CH-1:0]       ce,
  output logic                    lost,
  output logic [LOSS_W-1:0]       loss_count,
  output logic [1:0]              dbg_state
);

  localparam int CNT_MAX = (LOCK_CYCLES > RST_CYCLES) ? LOCK_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RST_HOLD  = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               lock_meta;
  logic               lock_s;
  logic               loss_event;
  logic [DIV_W-1:0]   ch_cnt [NUM_CH];

  assign dbg_state  = state;
  assign loss_event = (state == RUN) && !lock_s;

  always_ff @(posedge global_clock or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // A low lock_s is checked before any counter terminal so it always wins.
  always_ff @(posedge global_clock or posedge reset) begin
    if (reset) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= SETTLE;
            cnt   <= '0;
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (cnt == LOCK_LAST) begin
            state <= RST_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RST_HOLD: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (cnt == RST_LAST) begin
            state     <= RUN;
            sys_reset <= 1'b0;
            ready     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state     <= WAIT_LOCK;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
          end
        end
        default: begin
          state     <= WAIT_LOCK;
          sys_reset <= 1'b1;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  // Channel counters wrap naturally at 2^DIV_W, so a divisor lowered below the
  // current count is reached after the wrap.
  always_ff @(posedge global_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) ch_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((state == RUN) && lock_s) begin
          if (ch_cnt[i] == div[i*DIV_W +: DIV_W]) ch_cnt[i] <= '0;
          else                                   ch_cnt[i] <= ch_cnt[i] + DIV_W'(1);
        end else begin
          ch_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    ce = '0;
    for (int i = 0; i < NUM_CH; i++)
      ce[i] = (state == RUN) && (ch_cnt[i] == div[i*DIV_W +: DIV_W]);
  end

  always_ff @(posedge global_clock or posedge reset) begin
    if (reset)           lost <= 1'b0;
    else if (loss_event) lost <= 1'b1;
    else if (loss_clr)   lost <= 1'b0;
  end

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
  logic [LOSS_W-1:0] loss_cnt;

  // A loss in the same cycle as a clear leaves a count of one.
  always_ff @(posedge global_clock or posedge reset) begin
    if (reset) begin
      loss_cnt <= '0;
    end else if (loss_event) begin
      if (loss_clr)              loss_cnt <= LOSS_W'(1);
      else if (loss_cnt != '1)   loss_cnt <= loss_cnt + LOSS_W'(1);
    end else if (loss_clr) begin
      loss_cnt <= '0;
    end
  end

  assign loss_count = loss_cnt;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor: lock qualification, settle glitch, clock-enable
// vectors, lock-loss counting/saturation and mid-run reset.
module tb_pll_supervisor;

  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 4;
  localparam int LOCK_CYCLES = 8;
  localparam int RST_CYCLES  = 4;
  localparam int LOSS_W      = 8;
  localparam int QUAL        = 2 + 1 + LOCK_CYCLES + RST_CYCLES;
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic                    global_clock = 1'b0;
  logic                    reset;
  logic                    pll_lock;
  logic [NUM_CH*DIV_W-1:0] div;
  logic                    loss_clr;
  logic                    sys_reset;
  logic                    ready;
  logic [NUM_CH-1:0]       ce;
  logic                    lost;
  logic [LOSS_W-1:0]       loss_count;
  logic [1:0]              dbg_state;

  int checks = 0;
  int errors = 0;

  logic [LOSS_W-1:0] exp_q[$];
  int                exp_loss = 0;

  typedef struct {
    logic [NUM_CH*DIV_W-1:0] div;
    logic [NUM_CH-1:0]       exp_ce;
  } vec_t;
  vec_t vecs[$];

  pll_supervisor #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES),
    .RST_CYCLES(RST_CYCLES), .LOSS_W(LOSS_W)
  ) dut (
    .global_clock(global_clock),
    .reset(reset),
    .pll_lock(pll_lock),
    .div(div),
    .loss_clr(loss_clr),
    .sys_reset(sys_reset),
    .ready(ready),
    .ce(ce),
    .lost(lost),
    .loss_count(loss_count),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 global_clock = ~global_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge global_clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [7:0] d, input logic [1:0] e, input int n);
    vec_t v;
    v.div    = d;
    v.exp_ce = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic qualify(input string name);
    int n;
    pll_lock = 1'b1;
    wait_ready(n);
    check({name, "_latency"}, n, QUAL);
    check({name, "_sys_reset"}, sys_reset, 1'b0);
  endtask

  // Drop the lock for three cycles while in RUN; optionally clear in the loss cycle.
  task automatic lose(input logic clr);
    pll_lock = 1'b0;
    tick();
    tick();
    check("loss_still_ready", ready, 1'b1);
    loss_clr = clr;
    tick();
    loss_clr = 1'b0;
    if (clr) exp_loss = 1;
    else if (exp_loss < 255) exp_loss++;
    exp_q.push_back(LOSS_EN ? LOSS_W'(exp_loss) : '0);
    check("loss_sys_reset", sys_reset, 1'b1);
    check("loss_ready", ready, 1'b0);
    check("loss_lost", lost, 1'b1);
    check("loss_count", loss_count, exp_q.pop_front());
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_sys_reset"}, sys_reset, 1'b1);
    check({name, "_ready"}, ready, 1'b0);
    check({name, "_ce"}, ce, 2'b00);
    check({name, "_lost"}, lost, 1'b0);
    check({name, "_loss_count"}, loss_count, 8'd0);
    check({name, "_state"}, dbg_state, 2'd0);
  endtask

  initial begin
    int n;
    // RUN cycles 1..64 of ce behaviour, div = {ch1, ch0}
    add(8'h30, 2'b01, 3); add(8'h30, 2'b11, 1);
    add(8'h30, 2'b01, 3); add(8'h30, 2'b11, 1);
    add(8'h12, 2'b00, 1); add(8'h12, 2'b10, 1); add(8'h12, 2'b01, 1);
    add(8'h12, 2'b10, 1); add(8'h12, 2'b00, 1); add(8'h12, 2'b11, 1);
    add(8'hF0, 2'b01, 4);
    add(8'h10, 2'b01, 13); add(8'h10, 2'b11, 1);
    add(8'hF0, 2'b01, 15); add(8'hF0, 2'b11, 1);
    add(8'hF0, 2'b01, 15); add(8'hF0, 2'b11, 1);

    reset    = 1'b1;
    pll_lock = 1'b0;
    div      = 8'h30;
    loss_clr = 1'b0;
    tick();
    tick();
    check_reset_values("por");
    reset = 1'b0;
    tick();
    tick();
    check("idle_state", dbg_state, 2'd0);

    // lock dropped while SETTLE count is 5
    pll_lock = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("glitch_in_settle", dbg_state, 2'd1);
    pll_lock = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("glitch_to_wait", dbg_state, 2'd0);
    check("glitch_lost", lost, 1'b0);
    check("glitch_sys_reset", sys_reset, 1'b1);
    qualify("first_qual");

    foreach (vecs[k]) begin
      div = vecs[k].div;
      #1;
      check($sformatf("ce_vec%0d", k), ce, vecs[k].exp_ce);
      tick();
    end
    check("run_ready", ready, 1'b1);

    for (int i = 0; i < 3; i++) begin
      lose(1'b0);
      qualify("requal");
    end
    lose(1'b1);
    qualify("requal_clr");

    loss_clr = 1'b1;
    tick();
    loss_clr = 1'b0;
    exp_loss = 0;
    check("clr_loss_count", loss_count, 8'd0);
    check("clr_lost", lost, 1'b0);

    for (int i = 0; i < 300; i++) begin
      lose(1'b0);
      qualify("sat_requal");
    end
    check("sat_loss_count", loss_count, LOSS_EN ? 8'd255 : 8'd0);

    div = 8'hF0;
    tick();
    check("pre_reset_ce", ce, 2'b01);
    reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    #2;
    reset = 1'b0;
    wait_ready(n);
    check("post_reset_latency", n, QUAL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 Parameter NUM_CH, default 2: number of clock-enable channels, 1..8.
REQ-002 Parameter DIV_W, default 16: width of each channel divisor.
REQ-003 Parameter LOCK_CYCLES, default 1024: consecutive synchronised-lock cycles required before reset release, >=2.
REQ-004 Parameter RST_CYCLES, default 16: cycles sys_reset stays high after lock is qualified, >=1.
REQ-005 Parameter LOSS_W, default 8: width of the lock-loss counter.
REQ-006 global_clock  in  1  sole clock; all state on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset of all state.
REQ-008 pll_lock  in  1  raw PLL LOCK; asynchronous to global_clock.
REQ-009 div  in  NUM_CH*DIV_W  per-channel divisor D; channel i occupies bits [i*DIV_W +: DIV_W].
REQ-010 loss_clr  in  1  one-cycle request clearing loss_count and lost.
REQ-011 sys_reset  out  1  synchronous system reset for downstream logic, active-high.
REQ-012 ready  out  1  high only in state RUN.
REQ-013 ce  out  NUM_CH  per-channel one-cycle clock-enable strobes.
REQ-014 lost  out  1  sticky flag: lock lost while in RUN.
REQ-015 loss_count  out  LOSS_W  saturating count of lock losses in RUN.

Function
REQ-016 pll_lock SHALL pass through a 2-flop synchroniser; lock_s denotes its output (2-cycle latency).
REQ-017 FSM states SHALL be WAIT_LOCK, SETTLE, RST_HOLD, RUN; encoding free.
REQ-018 WAIT_LOCK: lock_s=1 -> SETTLE with cycle counter cleared to 0.
REQ-019 SETTLE: lock_s=0 -> WAIT_LOCK; counter == LOCK_CYCLES-1 with lock_s=1 -> RST_HOLD, counter cleared.
REQ-020 RST_HOLD: lock_s=0 -> WAIT_LOCK; counter == RST_CYCLES-1 -> RUN.
REQ-021 RUN: lock_s=0 -> WAIT_LOCK, lost set, loss_count incremented; otherwise remain.
REQ-022 lock_s=0 SHALL take priority over any counter terminal condition in the same cycle.
REQ-023 sys_reset SHALL be registered, high in every state except RUN, deasserting on the first RUN cycle.
REQ-024 ready SHALL be registered, equal to (state == RUN).
REQ-025 Per channel, a DIV_W counter SHALL be held at 0 outside RUN and ce[i] held low.
REQ-026 In RUN: counter == D -> ce[i]=1 and counter <- 0; else counter increments; first strobe on the (D+1)th RUN cycle.
REQ-027 D=0 SHALL give ce[i] high every RUN cycle; D=2^DIV_W-1 SHALL give period 2^DIV_W without counter overflow.
REQ-028 div changes SHALL take effect on the next comparison; if new D < current count, counter continues to wrap at 2^DIV_W then matches.
REQ-029 loss_count SHALL saturate at 2^LOSS_W-1.
REQ-030 loss_clr with no loss event: loss_count <- 0, lost <- 0; simultaneous loss event wins: loss_count <- 1, lost <- 1.
REQ-031 Lock glitches shorter than 2 cycles MAY be filtered by the synchroniser; any lock_s=0 SHALL be honoured.

Reset
REQ-032 reset assertion SHALL immediately force state WAIT_LOCK, sys_reset=1, ready=0, ce=0, lost=0, loss_count=0, all counters and synchroniser flops 0.
REQ-033 Mid-operation reset (any state) SHALL act identically; reset release SHALL require a full LOCK_CYCLES+RST_CYCLES requalification.

Configuration
REQ-034 Macro PLL_SUPERVISOR_LOSS_COUNT_EN defined: loss_count and loss_clr function as REQ-021/029/030.
REQ-035 Macro undefined: loss_count port SHALL remain and be tied to 0, no counter flops built; lost still set, cleared only by reset or loss_clr.

Verification (LOCK_CYCLES=8, RST_CYCLES=4, NUM_CH=2, DIV_W=4, macro defined)
REQ-036 pll_lock 0->1 held, reset released -> sys_reset falls and ready rises exactly 2+1+8+4 cycles after lock edge (±1 edge alignment, fixed per bench).
REQ-037 pll_lock drops for 3 cycles at SETTLE count 5 -> back to WAIT_LOCK, full 8-cycle settle restarts, no lost set.
REQ-038 RUN, div={4'd3,4'd0} -> ce[0] high every cycle, ce[1] pulses every 4th cycle, first on RUN cycle 4.
REQ-039 RUN, pll_lock low 3 cycles, three times -> loss_count=3, lost=1, sys_reset high within 3 cycles of each drop; loss_clr coincident with 4th loss -> loss_count=1.
REQ-040 Force 300 losses (LOSS_W=8) -> loss_count sticks at 255; reset asserted mid-RUN -> all outputs at reset values same cycle.
